// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// interrupt cause codes, mstatus bit positions and FSM state encodings.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TRAP_SAVE    = 3'd1,
    ST_TRAP_JUMP    = 3'd2,
    ST_MRET_RESTORE = 3'd3,
    ST_MRET_JUMP    = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Combinational interrupt selector: software interrupt wins over timer,
// and nothing is pending while the global machine interrupt enable is off.
module irq_prio
  import trap_ctrl_pkg::*;
(
  input  logic       i_globalEnable,
  input  logic       i_msiEnable,
  input  logic       i_msiPending,
  input  logic       i_mtiEnable,
  input  logic       i_mtiPending,
  output logic       o_pending,
  output logic [4:0] o_code
);

  // Pick the highest-priority enabled and pending interrupt source.
  always_comb begin
    o_pending = 1'b0;
    o_code    = 5'd0;
    if (i_globalEnable) begin
      if (i_msiEnable && i_msiPending) begin
        o_pending = 1'b1;
        o_code    = IRQ_CODE_MSI;
      end else if (i_mtiEnable && i_mtiPending) begin
        o_pending = 1'b1;
        o_code    = IRQ_CODE_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts exceptions, interrupts and mret in
// IDLE, then spends one cycle writing CSRs and one cycle redirecting fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            irq_ready_i,
  input  logic [XLEN-1:0] irq_pc_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            we_mepc_o,
  output logic [XLEN-1:0] wdata_mepc_o,
  output logic            we_mcause_o,
  output logic [XLEN-1:0] wdata_mcause_o,
  output logic            we_mtval_o,
  output logic [XLEN-1:0] wdata_mtval_o,
  output logic            exception_mie_req_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  trap_state_e     r_state;
  trap_state_e     w_nextState;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;

  logic            w_irqPending;
  logic [4:0]      w_irqCode;
  logic            w_idle;
  logic            w_takeExc;
  logic            w_takeIrq;
  logic            w_takeMret;
  logic [XLEN-1:0] w_irqCause;
  logic            w_unusedBits;

  irq_prio u_irqPrio (
    .i_globalEnable (mstatus_i[MSTATUS_MIE_BIT]),
    .i_msiEnable    (mie_i[3]),
    .i_msiPending   (mip_i[3]),
    .i_mtiEnable    (mie_i[7]),
    .i_mtiPending   (mip_i[7]),
    .o_pending      (w_irqPending),
    .o_code         (w_irqCode)
  );

  // Events are only looked at in IDLE; exception beats interrupt beats mret.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_takeExc  = w_idle && exc_valid_i;
  assign w_takeIrq  = w_idle && !exc_valid_i && irq_ready_i && w_irqPending;
  assign w_takeMret = w_idle && !exc_valid_i && !(irq_ready_i && w_irqPending) && mret_i;
  assign w_irqCause = {1'b1, {(XLEN-6){1'b0}}, w_irqCode};

  // CSR bits this block never looks at, gathered so they read as intentionally ignored.
  assign w_unusedBits = ^{mstatus_i[XLEN-1:8], mstatus_i[6:4], mstatus_i[2:0],
                          mie_i[XLEN-1:8], mie_i[6:4], mie_i[2:0],
                          mip_i[XLEN-1:8], mip_i[6:4], mip_i[2:0],
                          mtvec_i[1:0]};

  // State register; reset always returns to IDLE, aborting any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the trap's pc/cause/tval in the acceptance cycle for the save step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_cause <= '0;
      r_tval  <= '0;
    end else if (w_takeExc) begin
      r_pc    <= exc_pc_i;
      r_cause <= exc_cause_i;
      r_tval  <= exc_tval_i;
    end else if (w_takeIrq) begin
      r_pc    <= irq_pc_i;
      r_cause <= w_irqCause;
      r_tval  <= '0;
    end
  end

  // Sequence: IDLE -> SAVE -> JUMP for traps, IDLE -> RESTORE -> JUMP for mret.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_takeExc || w_takeIrq) begin
          w_nextState = ST_TRAP_SAVE;
        end else if (w_takeMret) begin
          w_nextState = ST_MRET_RESTORE;
        end
      end
      ST_TRAP_SAVE:    w_nextState = ST_TRAP_JUMP;
      ST_TRAP_JUMP:    w_nextState = ST_IDLE;
      ST_MRET_RESTORE: w_nextState = ST_MRET_JUMP;
      ST_MRET_JUMP:    w_nextState = ST_IDLE;
      default:         w_nextState = ST_IDLE;
    endcase
  end

  // Per-state pulses; everything is held at zero while reset is asserted.
  always_comb begin
    we_mepc_o           = 1'b0;
    wdata_mepc_o        = '0;
    we_mcause_o         = 1'b0;
    wdata_mcause_o      = '0;
    we_mtval_o          = 1'b0;
    wdata_mtval_o       = '0;
    exception_mie_req_o = 1'b0;
    csr_we_o            = 1'b0;
    csr_waddr_o         = 12'h000;
    csr_wdata_o         = '0;
    stall_o             = 1'b0;
    flush_o             = 1'b0;
    redirect_valid_o    = 1'b0;
    redirect_pc_o       = '0;
    busy_o              = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          stall_o = w_takeExc || w_takeIrq || w_takeMret;
        end
        ST_TRAP_SAVE: begin
          stall_o             = 1'b1;
          busy_o              = 1'b1;
          we_mepc_o           = 1'b1;
          wdata_mepc_o        = r_pc;
          we_mcause_o         = 1'b1;
          wdata_mcause_o      = r_cause;
          we_mtval_o          = 1'b1;
          wdata_mtval_o       = r_tval;
          exception_mie_req_o = 1'b1;
        end
        ST_TRAP_JUMP: begin
          stall_o          = 1'b1;
          busy_o           = 1'b1;
          flush_o          = 1'b1;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = {mtvec_i[XLEN-1:2], 2'b00};
        end
        ST_MRET_RESTORE: begin
          stall_o                       = 1'b1;
          busy_o                        = 1'b1;
          csr_we_o                      = 1'b1;
          csr_waddr_o                   = CSR_MSTATUS;
          csr_wdata_o[MSTATUS_MPIE_BIT] = 1'b1;
          csr_wdata_o[MSTATUS_MIE_BIT]  = mstatus_i[MSTATUS_MPIE_BIT];
        end
        ST_MRET_JUMP: begin
          stall_o          = 1'b1;
          busy_o           = 1'b1;
          flush_o          = 1'b1;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = mepc_i;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_trap_ctrl;

  localparam int XLEN = 64;

  typedef struct {
    logic        rst;
    logic        exc;
    logic [63:0] cause;
    logic [63:0] pc;
    logic [63:0] tval;
    logic        mret;
    logic        irqReady;
    logic [63:0] irqPc;
    logic [63:0] mstatus;
    logic [63:0] mie;
    logic [63:0] mip;
    logic [63:0] mtvec;
    logic [63:0] mepc;
  } stim_t;

  typedef struct {
    logic        stall;
    logic        busy;
    logic        flush;
    logic        rv;
    logic [63:0] rpc;
    logic        weMepc;
    logic [63:0] mepc;
    logic        weMcause;
    logic [63:0] mcause;
    logic        weMtval;
    logic [63:0] mtval;
    logic        mieReq;
    logic        csrWe;
    logic [11:0] csrAddr;
    logic [63:0] csrData;
  } exp_t;

  typedef struct {
    stim_t       s;
    int          kind;
    logic [63:0] ePc;
    logic [63:0] eCause;
    logic [63:0] eTval;
    logic [63:0] eCsr;
    logic [63:0] eTarget;
  } vec_t;

  typedef struct {
    int          kind;
    logic [63:0] pc;
    logic [63:0] cause;
    logic [63:0] tval;
  } action_t;

  localparam int K_NONE = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;
  localparam int A_SAVE = 1;
  localparam int A_TJMP = 2;
  localparam int A_REST = 3;
  localparam int A_MJMP = 4;

  logic clk = 1'b0;
  logic rst;
  logic exc_valid_i, mret_i, irq_ready_i;
  logic [XLEN-1:0] exc_cause_i, exc_pc_i, exc_tval_i, irq_pc_i;
  logic [XLEN-1:0] mstatus_i, mie_i, mip_i, mtvec_i, mepc_i;
  logic we_mepc_o, we_mcause_o, we_mtval_o, exception_mie_req_o, csr_we_o;
  logic [XLEN-1:0] wdata_mepc_o, wdata_mcause_o, wdata_mtval_o, csr_wdata_o, redirect_pc_o;
  logic [11:0] csr_waddr_o;
  logic stall_o, flush_o, redirect_valid_o, busy_o;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .exc_valid_i         (exc_valid_i),
    .exc_cause_i         (exc_cause_i),
    .exc_pc_i            (exc_pc_i),
    .exc_tval_i          (exc_tval_i),
    .mret_i              (mret_i),
    .irq_ready_i         (irq_ready_i),
    .irq_pc_i            (irq_pc_i),
    .mstatus_i           (mstatus_i),
    .mie_i               (mie_i),
    .mip_i               (mip_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .we_mepc_o           (we_mepc_o),
    .wdata_mepc_o        (wdata_mepc_o),
    .we_mcause_o         (we_mcause_o),
    .wdata_mcause_o      (wdata_mcause_o),
    .we_mtval_o          (we_mtval_o),
    .wdata_mtval_o       (wdata_mtval_o),
    .exception_mie_req_o (exception_mie_req_o),
    .csr_we_o            (csr_we_o),
    .csr_waddr_o         (csr_waddr_o),
    .csr_wdata_o         (csr_wdata_o),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_pc_o       (redirect_pc_o),
    .busy_o              (busy_o)
  );

  function automatic stim_t mkStim(input logic exc, input logic [63:0] cause,
                                   input logic [63:0] pc, input logic [63:0] tval,
                                   input logic mret, input logic irqReady,
                                   input logic [63:0] irqPc, input logic [63:0] mstatus,
                                   input logic [63:0] mie, input logic [63:0] mip,
                                   input logic [63:0] mtvec, input logic [63:0] mepc);
    stim_t s;
    s.rst = 1'b0; s.exc = exc; s.cause = cause; s.pc = pc; s.tval = tval;
    s.mret = mret; s.irqReady = irqReady; s.irqPc = irqPc; s.mstatus = mstatus;
    s.mie = mie; s.mip = mip; s.mtvec = mtvec; s.mepc = mepc;
    return s;
  endfunction

  function automatic stim_t quiet();
    return mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t zeroExp();
    exp_t e;
    e.stall = 0; e.busy = 0; e.flush = 0; e.rv = 0; e.rpc = 0;
    e.weMepc = 0; e.mepc = 0; e.weMcause = 0; e.mcause = 0;
    e.weMtval = 0; e.mtval = 0; e.mieReq = 0;
    e.csrWe = 0; e.csrAddr = 0; e.csrData = 0;
    return e;
  endfunction

  function automatic exp_t acceptExp(input logic taken);
    exp_t e = zeroExp();
    e.stall = taken;
    return e;
  endfunction

  function automatic exp_t saveExp(input logic [63:0] pc, input logic [63:0] cause,
                                   input logic [63:0] tval);
    exp_t e = zeroExp();
    e.stall = 1; e.busy = 1;
    e.weMepc = 1; e.mepc = pc;
    e.weMcause = 1; e.mcause = cause;
    e.weMtval = 1; e.mtval = tval;
    e.mieReq = 1;
    return e;
  endfunction

  function automatic exp_t jumpExp(input logic [63:0] target);
    exp_t e = zeroExp();
    e.stall = 1; e.busy = 1; e.flush = 1; e.rv = 1; e.rpc = target;
    return e;
  endfunction

  function automatic exp_t restoreExp(input logic [63:0] data);
    exp_t e = zeroExp();
    e.stall = 1; e.busy = 1; e.csrWe = 1; e.csrAddr = 12'h300; e.csrData = data;
    return e;
  endfunction

  task automatic checkField(input string name, input string field,
                            input logic [63:0] act, input logic [63:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; exc_valid_i = s.exc; exc_cause_i = s.cause; exc_pc_i = s.pc;
    exc_tval_i = s.tval; mret_i = s.mret; irq_ready_i = s.irqReady; irq_pc_i = s.irqPc;
    mstatus_i = s.mstatus; mie_i = s.mie; mip_i = s.mip; mtvec_i = s.mtvec; mepc_i = s.mepc;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checkField(name, "stall",    64'(stall_o),             64'(e.stall));
    checkField(name, "busy",     64'(busy_o),              64'(e.busy));
    checkField(name, "flush",    64'(flush_o),             64'(e.flush));
    checkField(name, "redirV",   64'(redirect_valid_o),    64'(e.rv));
    checkField(name, "redirPc",  redirect_pc_o,            e.rpc);
    checkField(name, "weMepc",   64'(we_mepc_o),           64'(e.weMepc));
    checkField(name, "mepc",     wdata_mepc_o,             e.mepc);
    checkField(name, "weMcause", 64'(we_mcause_o),         64'(e.weMcause));
    checkField(name, "mcause",   wdata_mcause_o,           e.mcause);
    checkField(name, "weMtval",  64'(we_mtval_o),          64'(e.weMtval));
    checkField(name, "mtval",    wdata_mtval_o,            e.mtval);
    checkField(name, "mieReq",   64'(exception_mie_req_o), 64'(e.mieReq));
    checkField(name, "csrWe",    64'(csr_we_o),            64'(e.csrWe));
    checkField(name, "csrAddr",  64'(csr_waddr_o),         64'(e.csrAddr));
    checkField(name, "csrData",  csr_wdata_o,              e.csrData);
  endtask

  task automatic stepCheck(input string name, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput(name, e);
  endtask

  // Reference model: event choice from the architectural rules, queued follow-up actions.
  action_t modelQ[$];

  function automatic exp_t resolve(input action_t a, input stim_t s);
    case (a.kind)
      A_SAVE:  return saveExp(a.pc, a.cause, a.tval);
      A_TJMP:  return jumpExp(s.mtvec & ~64'h3);
      A_REST:  return restoreExp(64'h80 | (s.mstatus[7] ? 64'h8 : 64'h0));
      default: return jumpExp(s.mepc);
    endcase
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst      = ($urandom_range(0, 39) == 0);
    s.exc      = ($urandom_range(0, 5) == 0);
    s.cause    = {$urandom, $urandom};
    s.pc       = {$urandom, $urandom};
    s.tval     = {$urandom, $urandom};
    s.mret     = ($urandom_range(0, 4) == 0);
    s.irqReady = 1'($urandom_range(0, 1));
    s.irqPc    = {$urandom, $urandom};
    s.mstatus  = {$urandom, $urandom};
    s.mie      = {$urandom, $urandom};
    s.mip      = {$urandom, $urandom};
    s.mtvec    = {$urandom, $urandom};
    s.mepc     = {$urandom, $urandom};
    return s;
  endfunction

  vec_t vecs[8];

  initial begin
    stim_t s;
    stim_t s2;
    exp_t  e;

    vecs[0] = '{mkStim(1, 2, 64'h8000_0010, 64'hDEAD, 0, 0, 0, 0, 0, 0, 64'h8000_0100, 0),
                K_TRAP, 64'h8000_0010, 64'd2, 64'hDEAD, 0, 64'h8000_0100};
    vecs[1] = '{mkStim(0, 0, 0, 64'h55, 0, 1, 64'h8000_0024, 64'h8, 64'h88, 64'h88, 64'h8000_0103, 0),
                K_TRAP, 64'h8000_0024, 64'h8000_0000_0000_0003, 0, 0, 64'h8000_0100};
    vecs[2] = '{mkStim(0, 0, 0, 0, 1, 0, 0, 64'h80, 0, 0, 0, 64'h8000_0040),
                K_MRET, 0, 0, 0, 64'h88, 64'h8000_0040};
    vecs[3] = '{mkStim(0, 0, 0, 0, 1, 0, 0, 64'h08, 0, 0, 0, 64'h1234),
                K_MRET, 0, 0, 0, 64'h80, 64'h1234};
    vecs[4] = '{mkStim(0, 0, 0, 0, 0, 1, 64'h4000, 64'h8, 64'h80, 64'h88, 64'h200, 0),
                K_TRAP, 64'h4000, 64'h8000_0000_0000_0007, 0, 0, 64'h200};
    vecs[5] = '{mkStim(0, 0, 0, 0, 1, 0, 64'h9000, 64'h88, 64'h8, 64'h8, 0, 64'h8000_0080),
                K_MRET, 0, 0, 0, 64'h88, 64'h8000_0080};
    vecs[6] = '{mkStim(0, 0, 0, 0, 0, 1, 64'h9000, 64'h80, 64'h88, 64'h88, 0, 0),
                K_NONE, 0, 0, 0, 0, 0};
    vecs[7] = '{mkStim(1, 64'hB, 64'h100, 64'h7, 1, 1, 64'h9000, 64'h8, 64'h8, 64'h8, 64'h300, 0),
                K_TRAP, 64'h100, 64'hB, 64'h7, 0, 64'h300};

    // Reset with events pending: everything must stay at zero.
    s = vecs[0].s;
    s.rst = 1'b1;
    s.mret = 1'b1;
    applyStimulus(s);
    stepCheck("reset0", s, zeroExp());
    stepCheck("reset1", s, zeroExp());
    stepCheck("postReset", quiet(), acceptExp(0));

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].kind == K_NONE) begin
        stepCheck({nm, ".accept"}, vecs[i].s, acceptExp(0));
      end else begin
        stepCheck({nm, ".accept"}, vecs[i].s, acceptExp(1));
        if (vecs[i].kind == K_TRAP) begin
          stepCheck({nm, ".save"}, vecs[i].s, saveExp(vecs[i].ePc, vecs[i].eCause, vecs[i].eTval));
        end else begin
          stepCheck({nm, ".restore"}, vecs[i].s, restoreExp(vecs[i].eCsr));
        end
        stepCheck({nm, ".jump"}, vecs[i].s, jumpExp(vecs[i].eTarget));
      end
      stepCheck({nm, ".idle"}, quiet(), acceptExp(0));
    end

    // Simultaneous exception/irq/mret, then back-to-back irq, then MIE gating.
    s = mkStim(1, 5, 64'h2000, 64'h11, 1, 1, 64'h3000, 64'h8, 64'h8, 64'h8, 64'h400, 64'h5000);
    stepCheck("simul.accept", s, acceptExp(1));
    stepCheck("simul.save", s, saveExp(64'h2000, 64'd5, 64'h11));
    stepCheck("simul.jump", s, jumpExp(64'h400));
    s2 = s;
    s2.exc = 1'b0;
    s2.mret = 1'b0;
    stepCheck("b2b.accept", s2, acceptExp(1));
    stepCheck("b2b.save", s2, saveExp(64'h3000, 64'h8000_0000_0000_0003, 0));
    stepCheck("b2b.jump", s2, jumpExp(64'h400));
    s2.mstatus = 64'h80;
    for (int k = 0; k < 3; k++) begin
      stepCheck($sformatf("mieOff%0d", k), s2, acceptExp(0));
    end
    s2.mstatus = 64'h8;
    stepCheck("mieOn.accept", s2, acceptExp(1));
    stepCheck("mieOn.save", s2, saveExp(64'h3000, 64'h8000_0000_0000_0003, 0));
    stepCheck("mieOn.jump", s2, jumpExp(64'h400));
    stepCheck("mieOn.idle", quiet(), acceptExp(0));

    // Reset in the save cycle aborts the trap entirely.
    s = vecs[0].s;
    stepCheck("abort.accept", s, acceptExp(1));
    s.rst = 1'b1;
    stepCheck("abort.rst", s, zeroExp());
    stepCheck("abort.idle", quiet(), acceptExp(0));
    stepCheck("abort.idle2", quiet(), acceptExp(0));

    // Randomized traffic against the reference model.
    modelQ.delete();
    for (int n = 0; n < 3000; n++) begin
      action_t a;
      logic [63:0] act;
      logic        irqPend;
      logic [63:0] irqCause;
      s = randStim();
      @(posedge clk);
      #1;
      applyStimulus(s);
      act      = s.mie & s.mip;
      irqPend  = s.mstatus[3] && (act[3] || act[7]);
      irqCause = 64'h8000_0000_0000_0000 + (act[3] ? 64'd3 : 64'd7);
      if (s.rst) begin
        e = zeroExp();
        modelQ.delete();
      end else if (modelQ.size() > 0) begin
        e = resolve(modelQ.pop_front(), s);
      end else if (s.exc || (s.irqReady && irqPend) || s.mret) begin
        e = acceptExp(1);
        if (s.exc || (s.irqReady && irqPend)) begin
          a.kind  = A_SAVE;
          a.pc    = s.exc ? s.pc : s.irqPc;
          a.cause = s.exc ? s.cause : irqCause;
          a.tval  = s.exc ? s.tval : 64'd0;
          modelQ.push_back(a);
          a.kind = A_TJMP;
          modelQ.push_back(a);
        end else begin
          a.kind = A_REST; a.pc = 0; a.cause = 0; a.tval = 0;
          modelQ.push_back(a);
          a.kind = A_MJMP;
          modelQ.push_back(a);
        end
      end else begin
        e = acceptExp(0);
      end
      @(negedge clk);
      checkOutput($sformatf("rand%0d", n), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the width of PC, cause, tval and CSR data.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have the following pipeline inputs: exc_valid_i 1 (synchronous exception pending); exc_cause_i XLEN; exc_pc_i XLEN (faulting PC); exc_tval_i XLEN; mret_i 1; irq_ready_i 1 (instruction boundary reached); irq_pc_i XLEN (next PC for interrupt return).
REQ-005 The block SHALL have the following CSR-state inputs: mstatus_i XLEN, mie_i XLEN, mip_i XLEN, mtvec_i XLEN and mepc_i XLEN.
REQ-006 The block SHALL have the following CSR write outputs: we_mepc_o/wdata_mepc_o, we_mcause_o/wdata_mcause_o, we_mtval_o/wdata_mtval_o (1/XLEN each); exception_mie_req_o 1; csr_we_o 1, csr_waddr_o 12, csr_wdata_o XLEN (generic port, used for mret only).
REQ-007 The block SHALL have the following pipeline control outputs: stall_o 1, flush_o 1, redirect_valid_o 1, redirect_pc_o XLEN, busy_o 1.

Function
REQ-008 The FSM SHALL have states IDLE, TRAP_SAVE, TRAP_JUMP, MRET_RESTORE and MRET_JUMP.
REQ-009 In IDLE, the block SHALL select the event using priority exc_valid_i > pending interrupt (when irq_ready_i is high) > mret_i.
REQ-010 An interrupt SHALL be pending when mstatus_i[3]=1 and (mie_i[3]&mip_i[3] | mie_i[7]&mip_i[7]); software (code 3) SHALL take priority over timer (code 7).
REQ-011 On event acceptance, the block SHALL latch pc/cause/tval in the same cycle and assert stall_o combinationally.
- Exception: pc=exc_pc_i, cause=exc_cause_i, tval=exc_tval_i.
- Interrupt: pc=irq_pc_i, cause={1'b1, zeros, code[4:0]}, tval=0.
- The next state SHALL be TRAP_SAVE, or MRET_RESTORE for mret.
REQ-012 In TRAP_SAVE, for exactly one cycle, the block SHALL assert we_mepc_o, we_mcause_o, we_mtval_o and exception_mie_req_o with the latched data, then go to TRAP_JUMP.
REQ-013 In TRAP_JUMP, for one cycle, the block SHALL assert redirect_valid_o and flush_o with redirect_pc_o={mtvec_i[XLEN-1:2], 2'b00}, then go to IDLE.
REQ-014 In MRET_RESTORE, for one cycle, the block SHALL assert csr_we_o with csr_waddr_o=12'h300 and csr_wdata_o having bit7=1, bit3=mstatus_i[7] and all other bits 0.
REQ-015 In MRET_JUMP, for one cycle, the block SHALL assert redirect_valid_o and flush_o with redirect_pc_o=mepc_i, then go to IDLE.
REQ-016 stall_o and busy_o SHALL be high in every non-IDLE state; stall_o SHALL also be high in the IDLE acceptance cycle.
REQ-017 Trap and mret latency from acceptance to redirect SHALL be exactly 2 cycles.
REQ-018 Inputs SHALL be ignored while not in IDLE; events present in the TRAP_JUMP/MRET_JUMP cycle SHALL NOT be accepted until the following IDLE cycle.
REQ-019 Back-to-back traps SHALL be permitted: IDLE may accept a new event on the cycle after a JUMP state.
REQ-020 The block SHALL NOT retake an interrupt taken via exception_mie_req_o while mstatus_i[3]=0.
REQ-021 All write-enable and redirect outputs SHALL be single-cycle pulses; when deasserted, the corresponding data outputs SHALL be 0.
REQ-022 wdata_mepc_o SHALL carry the full XLEN PC; low-bit truncation is the CSR file's responsibility.

Reset
REQ-023 While rst=1, the state SHALL be IDLE, all outputs 0 and latched pc/cause/tval 0.
REQ-024 A reset in any non-IDLE state SHALL abort the sequence with no CSR write or redirect in that cycle.

Structure
REQ-025 The shared defines file SHALL hold the CSR addresses (mstatus 12'h300, mepc, mcause, mtval), interrupt cause codes 3/7, mstatus bit positions 3/7 and the FSM state encodings.
REQ-026 Interrupt selection SHALL live in one combinational sub-module, irq_prio; the FSM and latches SHALL reside in trap_ctrl.

Verification
REQ-027 Exception: exc_valid_i with cause 2, pc 0x8000_0010, tval 0xDEAD, mtvec 0x8000_0100 -> TRAP_SAVE writes mepc=0x8000_0010, mcause=2, mtval=0xDEAD and MIE req; redirect 0x8000_0100 two cycles after acceptance.
REQ-028 Interrupt: mstatus=0x8, mie=mip=0x88, irq_ready_i=1, irq_pc_i=0x8000_0024 -> mcause=0x8000_0000_0000_0003, mepc=0x8000_0024, mtval=0.
REQ-029 Mret: mstatus=0x80, mepc=0x8000_0040 -> csr write addr 0x300 data 0x88; redirect 0x8000_0040 two cycles after acceptance.
REQ-030 Simultaneous exc_valid_i, pending interrupt and mret_i -> exception taken; the interrupt is taken only after the sequence, provided MIE has been re-enabled.
REQ-031 rst asserted during TRAP_SAVE -> no mepc/mcause/mtval write and no redirect; FSM is IDLE and all outputs are 0 the next cycle.
